mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_prio.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   localparam logic       OWN_IF    = 1'b0;
   localparam logic       OWN_D     = 1'b1;
   localparam logic [3:0] MASK_NONE = 4'b0000;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data requesters.
// Data wins by default; fetch wins once it has lost STARVE_MAX times in a row.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic d_req,
   input  logic decide_en,
   output logic gnt_if,
   output logic gnt_d
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_q, starve_d;
   logic       fetch_due;

   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
      fetch_due = if_req && (starve_q == STARVE_LIM);
      gnt_d     = decide_en && d_req && !fetch_due;
      gnt_if    = decide_en && if_req && !gnt_d;
      starve_d  = starve_q;
      if (gnt_if) begin
         starve_d = '0;
      end else if (gnt_d && if_req && (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store,
// sequencing ISSUE/WAIT/RESP and stalling the core while an access is in flight.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_mask,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_request,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_we_re,
   output logic [3:0]        mem_masking,
   output logic [DATA_W-1:0] mem_w_data,
   input  logic [DATA_W-1:0] mem_r_data,
   output logic              stall
);

   localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

   arb_state_e        state_q, state_d;
   logic [2:0]        lat_q, lat_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [3:0]        mask_q, mask_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic decide_state, decide_en, gnt_if, gnt_d, in_issue, in_resp;

   // Reset gates the decision so grants and stall drop without waiting for an edge.
   assign decide_state = (state_q == IDLE) || (state_q == RESP);
   assign decide_en    = !rst && decide_state;

   mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .d_req     (d_req),
      .decide_en (decide_en),
      .gnt_if    (gnt_if),
      .gnt_d     (gnt_d)
   );

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      we_d    = we_q;
      mask_d  = mask_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE, RESP: begin
            if (gnt_d) begin
               owner_d = OWN_D;
               addr_d  = d_addr;
               we_d    = d_we;
               mask_d  = d_we ? d_mask : MASK_NONE;
               wdata_d = d_we ? d_wdata : '0;
               state_d = ISSUE;
            end else if (gnt_if) begin
               owner_d = OWN_IF;
               addr_d  = if_addr;
               we_d    = 1'b0;
               mask_d  = MASK_NONE;
               wdata_d = '0;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            lat_d   = LAT_LOAD;
            state_d = WAIT;
         end
         WAIT: begin
            if (lat_q == 3'd0) begin
               rdata_d = mem_r_data;
               state_d = RESP;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lat_q   <= '0;
         owner_q <= OWN_IF;
         addr_q  <= '0;
         we_q    <= 1'b0;
         mask_q  <= MASK_NONE;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         mask_q  <= mask_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign in_issue = (state_q == ISSUE);
   assign in_resp  = (state_q == RESP);

   assign if_gnt      = gnt_if;
   assign d_gnt       = gnt_d;
   assign mem_request = in_issue;
   assign mem_address = in_issue ? addr_q : '0;
   assign mem_we_re   = in_issue && we_q;
   assign mem_masking = in_issue ? mask_q : MASK_NONE;
   assign mem_w_data  = in_issue ? wdata_q : '0;

   assign if_rvalid = in_resp && (owner_q == OWN_IF);
   assign d_rvalid  = in_resp && (owner_q == OWN_D);
   assign if_rdata  = if_rvalid ? rdata_q : '0;
   // A completed store reports zero data.
   assign d_rdata   = (d_rvalid && !we_q) ? rdata_q : '0;

   assign stall = !rst && !(decide_state && !gnt_if && !gnt_d);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected read data is queued at grant and popped on rvalid.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   // Main instance, MEM_LAT = 1
   logic        if_req = 1'b0, if_gnt, if_rvalid;
   logic [7:0]  if_addr = '0;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid;
   logic [7:0]  d_addr = '0;
   logic [31:0] d_wdata = '0, d_rdata;
   logic [3:0]  d_mask = '0;
   logic        mem_request, mem_we_re, stall;
   logic [7:0]  mem_address;
   logic [3:0]  mem_masking;
   logic [31:0] mem_w_data, mem_r_data;

   // Second instance, MEM_LAT = 3, fed a cycle-stamped read bus
   logic        if_req3 = 1'b0, if_gnt3, if_rvalid3;
   logic [7:0]  if_addr3 = '0;
   logic [31:0] if_rdata3;
   logic        d_gnt3, d_rvalid3;
   logic [31:0] d_rdata3;
   logic        mem_request3, mem_we_re3, stall3;
   logic [7:0]  mem_address3;
   logic [3:0]  mem_masking3;
   logic [31:0] mem_w_data3, mem_r_data3;

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;
   assign mem_r_data3 = 32'hBEE0_0000 | cyc;

   int checks = 0;
   int failures = 0;
   logic [31:0] if_q[$];
   logic [31:0] d_q[$];

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_request(mem_request), .mem_address(mem_address), .mem_we_re(mem_we_re),
      .mem_masking(mem_masking), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
      .stall(stall)
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .rst(rst),
      .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
      .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(32'h0), .d_mask(4'h0),
      .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
      .mem_request(mem_request3), .mem_address(mem_address3), .mem_we_re(mem_we_re3),
      .mem_masking(mem_masking3), .mem_w_data(mem_w_data3), .mem_r_data(mem_r_data3),
      .stall(stall3)
   );

   // Memory model: unwritten words read back a fixed per-address pattern.
   function automatic logic [31:0] init_word(input logic [7:0] a);
      return (a == 8'h10) ? 32'h0050_0093 : {24'hC0DE00, a};
   endfunction

   logic [31:0] mem [256];
   bit          written [256];
   always @(posedge clk) begin
      if (mem_request) begin
         if (mem_we_re) begin
            logic [31:0] w;
            w = written[mem_address] ? mem[mem_address] : init_word(mem_address);
            for (int b = 0; b < 4; b++)
               if (mem_masking[b]) w[b*8 +: 8] = mem_w_data[b*8 +: 8];
            mem[mem_address]     <= w;
            written[mem_address] <= 1'b1;
         end else begin
            mem_r_data <= written[mem_address] ? mem[mem_address] : init_word(mem_address);
         end
      end
   end

   task automatic pop_compare(input bit is_d, input logic [31:0] got, input string name);
      logic [31:0] exp;
      checks++;
      if (is_d ? (d_q.size() == 0) : (if_q.size() == 0)) begin
         failures++;
         $display("FAIL %s: unexpected rvalid, data %h", name, got);
      end else begin
         exp = is_d ? d_q.pop_front() : if_q.pop_front();
         if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
         end
      end
   endtask

   task automatic wait_resp(input bit is_d);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ((is_d ? if_rvalid : d_rvalid) !== 1'b0) begin
            failures++;
            $display("FAIL stray_rvalid: wrong requester got a response");
         end
         if (is_d && d_rvalid) begin pop_compare(1'b1, d_rdata, "d_rdata"); return; end
         if (!is_d && if_rvalid) begin pop_compare(1'b0, if_rdata, "if_rdata"); return; end
      end
      checks++; failures++;
      $display("FAIL resp_timeout: no rvalid within 20 cycles (is_d=%0d)", is_d);
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if ({mem_request, stall, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_address, mem_masking} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {mem_request, stall, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_address, mem_masking});
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall: got %b expected 0", stall); end
   endtask

   task automatic test_single_fetch;
      @(posedge clk); #1 if_req = 1'b1; if_addr = 8'h10;
      if_q.push_back(32'h0050_0093);
      @(negedge clk);
      checks++; if ({if_gnt, d_gnt, stall} !== 3'b101) begin failures++; $display("FAIL fetch_T: gnt/dgnt/stall got %b expected 101", {if_gnt, d_gnt, stall}); end
      @(posedge clk); #1 if_req = 1'b0;
      @(negedge clk);
      checks++; if ({mem_request, mem_we_re, stall} !== 3'b101) begin failures++; $display("FAIL fetch_T1: req/we/stall got %b expected 101", {mem_request, mem_we_re, stall}); end
      checks++; if (mem_address !== 8'h10) begin failures++; $display("FAIL fetch_addr: got %h expected 10", mem_address); end
      @(negedge clk);
      checks++; if ({mem_request, if_rvalid, stall} !== 3'b001) begin failures++; $display("FAIL fetch_T2: req/rvalid/stall got %b expected 001", {mem_request, if_rvalid, stall}); end
      @(negedge clk);
      checks++; if ({if_rvalid, stall} !== 2'b10) begin failures++; $display("FAIL fetch_T3: rvalid/stall got %b expected 10", {if_rvalid, stall}); end
      if (if_rvalid) pop_compare(1'b0, if_rdata, "fetch_rdata");
   endtask

   task automatic test_store_load;
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'hDEAD_BEEF; d_mask = 4'b1111;
      d_q.push_back(32'h0);
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL store_gnt: got %b expected 1", d_gnt); end
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      checks++; if ({mem_request, mem_we_re, mem_masking} !== 6'b11_1111) begin failures++; $display("FAIL store_issue: req/we/mask got %b expected 111111", {mem_request, mem_we_re, mem_masking}); end
      checks++; if ({mem_address, mem_w_data} !== {8'h20, 32'hDEAD_BEEF}) begin failures++; $display("FAIL store_bus: got %h/%h expected 20/deadbeef", mem_address, mem_w_data); end
      wait_resp(1'b1);
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_mask = 4'b0000; d_wdata = 32'h0;
      d_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL load_gnt: got %b expected 1", d_gnt); end
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      checks++; if ({mem_request, mem_we_re, mem_masking} !== 6'b10_0000) begin failures++; $display("FAIL load_issue: req/we/mask got %b expected 100000", {mem_request, mem_we_re, mem_masking}); end
      wait_resp(1'b1);
   endtask

   task automatic test_contention;
      bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      int n = 0;
      int last = 0;
      @(posedge clk); #1 if_req = 1'b1; if_addr = 8'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
      for (int c = 0; c < 60 && n < 10; c++) begin
         @(negedge clk);
         if (if_rvalid) pop_compare(1'b0, if_rdata, "cont_if_rdata");
         if (d_rvalid)  pop_compare(1'b1, d_rdata, "cont_d_rdata");
         if (if_gnt || d_gnt) begin
            checks++;
            if ({d_gnt, if_gnt} !== {exp_d[n], !exp_d[n]}) begin
               failures++;
               $display("FAIL grant_order[%0d]: d/if got %b%b expected %b%b", n, d_gnt, if_gnt, exp_d[n], !exp_d[n]);
            end
            if (n > 0) begin
               checks++;
               if (c - last != 3) begin failures++; $display("FAIL grant_spacing[%0d]: got %0d expected 3", n, c - last); end
            end
            if (d_gnt) d_q.push_back(init_word(8'h30));
            else       if_q.push_back(init_word(8'h10));
            last = c;
            n++;
         end
      end
      checks++; if (n != 10) begin failures++; $display("FAIL grant_count: got %0d expected 10", n); end
      @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
      for (int c = 0; c < 20 && (if_q.size() + d_q.size()) != 0; c++) begin
         @(negedge clk);
         if (if_rvalid) pop_compare(1'b0, if_rdata, "cont_if_rdata");
         if (d_rvalid)  pop_compare(1'b1, d_rdata, "cont_d_rdata");
      end
      checks++; if ((if_q.size() + d_q.size()) != 0) begin failures++; $display("FAIL cont_drain: got %0d pending expected 0", if_q.size() + d_q.size()); end
   endtask

   task automatic test_lat3;
      @(posedge clk); #1 if_req3 = 1'b1; if_addr3 = 8'h44;
      @(negedge clk);
      checks++; if (if_gnt3 !== 1'b1) begin failures++; $display("FAIL lat3_gnt: got %b expected 1", if_gnt3); end
      if_q.push_back(32'hBEE0_0000 | (cyc + 32'd4));
      @(posedge clk); #1 if_req3 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checks++; if (mem_request3 !== (k == 1)) begin failures++; $display("FAIL lat3_req[T+%0d]: got %b expected %b", k, mem_request3, k == 1); end
         checks++; if (if_rvalid3 !== (k == 5)) begin failures++; $display("FAIL lat3_rvalid[T+%0d]: got %b expected %b", k, if_rvalid3, k == 5); end
         checks++; if ({d_gnt3, d_rvalid3, d_rdata3, mem_we_re3, mem_masking3, mem_w_data3} !== '0) begin failures++; $display("FAIL lat3_idle_d[T+%0d]: data-side output nonzero", k); end
         if (k == 1) begin
            checks++; if (mem_address3 !== 8'h44) begin failures++; $display("FAIL lat3_addr: got %h expected 44", mem_address3); end
         end
         if (if_rvalid3) pop_compare(1'b0, if_rdata3, "lat3_rdata");
      end
      checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL lat3_stall: got %b expected 0", stall3); end
   endtask

   task automatic test_mid_reset;
      @(posedge clk); #1 if_req = 1'b1; if_addr = 8'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
      @(negedge clk);
      checks++; if ({d_gnt, if_gnt} !== 2'b10) begin failures++; $display("FAIL mr_gnt: d/if got %b expected 10", {d_gnt, if_gnt}); end
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      checks++; if (dut.u_prio.starve_q !== 4'd1) begin failures++; $display("FAIL mr_starve_pre: got %0d expected 1", dut.u_prio.starve_q); end
      @(posedge clk); #2;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mr_wait_stall: got %b expected 1", stall); end
      rst = 1'b1;
      #1;
      checks++;
      if ({mem_request, stall, if_rvalid, d_rvalid, if_gnt, d_gnt} !== 6'b0) begin
         failures++;
         $display("FAIL mr_async: req/stall/ifv/dv/ifg/dg got %b expected 000000", {mem_request, stall, if_rvalid, d_rvalid, if_gnt, d_gnt});
      end
      repeat (2) begin
         @(negedge clk);
         checks++; if ({d_rvalid, stall, if_gnt} !== 3'b0) begin failures++; $display("FAIL mr_hold: dv/stall/ifg got %b expected 000", {d_rvalid, stall, if_gnt}); end
      end
      @(posedge clk); #1 rst = 1'b0;
      if_q.push_back(32'h0050_0093);
      @(negedge clk);
      checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL mr_if_gnt: got %b expected 1", if_gnt); end
      checks++; if (dut.u_prio.starve_q !== 4'd0) begin failures++; $display("FAIL mr_starve_post: got %0d expected 0", dut.u_prio.starve_q); end
      @(posedge clk); #1 if_req = 1'b0;
      wait_resp(1'b0);
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store_load();
      test_contention();
      test_lat3();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
